// File: rtl/nios_button_pio.sv
// Avalon-MM input PIO for push-buttons and switches.
// Each input bit passes through a two-flop synchronizer and an optional
// debounce filter; selected edges of the filtered value are latched into a
// sticky edge-capture register that, gated by irqmask, drives the interrupt.
//
// Register map (bits above WIDTH-1 read as 0):
//   0  data        debounced input value, read-only
//   1  (reserved)  reads 0
//   2  irqmask     read/write
//   3  edgecapture read, write-1-to-clear
module nios_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int RESET_LEVEL     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] RST_VEC = (RESET_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    // Counter width is clog2(N+1); kept at least 1 so the bypass build stays legal.
    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sync_s1;
    logic [WIDTH-1:0] sync_s2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] wdata;
    logic             wr_mask;
    logic             wr_clear;

    assign wdata    = writedata[WIDTH-1:0];
    assign wr_mask  = chipselect && !write_n && (address == 2'd2);
    assign wr_clear = chipselect && !write_n && (address == 2'd3);

    // Write data above WIDTH is ignored by the register file.
    generate
        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_s1 <= RST_VEC;
            sync_s2 <= RST_VEC;
        end else begin
            sync_s1 <= in_port;
            sync_s2 <= sync_s1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: the synchronized value is accepted every cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    deb <= RST_VEC;
                end else begin
                    deb <= sync_s2;
                end
            end
        end else begin : g_debounce
            localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt [WIDTH];

            // Per-bit filter: a new level is accepted only after it has been
            // seen for DEBOUNCE_CYCLES consecutive cycles; any return to the
            // accepted level restarts the count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    deb <= RST_VEC;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync_s2[i] == deb[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == TC) begin
                            deb[i] <= sync_s2[i];
                            cnt[i] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // Edge selection on the debounced value against its previous sample.
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = deb & ~deb_d;
            1:       edge_det = ~deb & deb_d;
            default: edge_det = deb ^ deb_d;
        endcase
    end

    // Edge history, sticky capture (a new edge beats a same-cycle clear) and mask.
    // deb_d resets with deb so a reset-induced level change is never captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_d       <= RST_VEC;
            edgecapture <= '0;
            irqmask     <= '0;
        end else begin
            deb_d       <= deb;
            edgecapture <= (edgecapture & ~(wr_clear ? wdata : {WIDTH{1'b0}})) | edge_det;
            if (wr_mask) begin
                irqmask <= wdata;
            end
        end
    end

    // Zero-latency read mux; independent of chipselect and free of side effects.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = deb;
            2'd2:    readdata[WIDTH-1:0] = irqmask;
            2'd3:    readdata[WIDTH-1:0] = edgecapture;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios_button_pio.sv
module tb_nios_button_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic        irq_a;
    logic        irq_b;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    // Debounced, falling-edge instance.
    nios_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_LEVEL(1)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_a), .irq(irq_a));

    // Bypass, any-edge instance sharing the bus.
    nios_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .RESET_LEVEL(1)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .in_port(in_b), .irq(irq_b));

    // Reference model: hist[d][0] is the input sampled at the latest edge,
    // hist[d][k] the one sampled k edges earlier.
    logic [3:0] hist [2][8];
    logic [3:0] m_deb  [2];
    logic [3:0] m_debd [2];
    logic [3:0] m_ec   [2];
    logic [3:0] m_mask;

    function automatic int hold_len(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    function automatic logic [31:0] m_read(input int d, input int a);
        case (a)
            0:       return {28'd0, m_deb[d]};
            2:       return {28'd0, m_mask};
            3:       return {28'd0, m_ec[d]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic [3:0] ia, input logic [3:0] ib,
                              input logic wm, input logic wc, input logic [3:0] wd);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int k = 0; k < 8; k++) hist[d][k] = 4'hF;
                m_deb[d]  = 4'hF;
                m_debd[d] = 4'hF;
                m_ec[d]   = 4'h0;
            end else begin
                logic [3:0] ev;
                logic [3:0] nd;
                // falling: was 1, now 0; any: level differs from previous
                ev = (d == 0) ? (m_debd[d] & ~m_deb[d]) : (m_debd[d] ^ m_deb[d]);
                m_ec[d] = (wc ? (m_ec[d] & ~wd) : m_ec[d]) | ev;
                m_debd[d] = m_deb[d];
                nd = m_deb[d];
                for (int b = 0; b < 4; b++) begin
                    if (hold_len(d) == 0) begin
                        nd[b] = hist[d][1][b];
                    end else begin
                        logic steady;
                        steady = 1'b1;
                        for (int k = 1; k <= hold_len(d); k++)
                            if (hist[d][k][b] != hist[d][1][b]) steady = 1'b0;
                        if (steady) nd[b] = hist[d][1][b];
                    end
                end
                m_deb[d] = nd;
                for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = (d == 0) ? ia : ib;
            end
        end
        if (rst) m_mask = 4'h0;
        else if (wm) m_mask = wd;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [1:0] saved;
        saved = address;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            chk($sformatf("model_a_addr%0d", a), rd_a, m_read(0, a));
            chk($sformatf("model_b_addr%0d", a), rd_b, m_read(1, a));
        end
        address = saved;
        chk("model_irq_a", {31'd0, irq_a}, {31'd0, |(m_ec[0] & m_mask)});
        chk("model_irq_b", {31'd0, irq_b}, {31'd0, |(m_ec[1] & m_mask)});
    endtask

    task automatic tick();
        logic r, wm, wc;
        logic [3:0] ia, ib, wd;
        r  = reset;
        wm = chipselect && !write_n && (address == 2'd2);
        wc = chipselect && !write_n && (address == 2'd3);
        wd = writedata[3:0];
        ia = in_a;
        ib = in_b;
        @(posedge clk);
        model_edge(r, ia, ib, wm, wc, wd);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = data;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
    endtask

    task automatic read_chk(input string tag, input int d, input int a, input logic [31:0] exp);
        address = 2'(a);
        #1;
        chk(tag, (d == 0) ? rd_a : rd_b, exp);
        address = 2'd0;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_a       = 4'hF;
        in_b       = 4'hF;
        ticks(2);
        reset = 1'b0;

        // Reset values
        read_chk("rst_data", 0, 0, 32'h0000000F);
        read_chk("rst_mask", 0, 2, 32'h0);
        read_chk("rst_edge", 0, 3, 32'h0);
        chk("rst_irq", {31'd0, irq_a}, 32'd0);

        // Held 0xE: data at edge 6, capture at edge 7, masked irq stays low
        in_a = 4'hE;
        ticks(5);
        read_chk("deb_edge5", 0, 0, 32'hF);
        tick();
        read_chk("deb_edge6", 0, 0, 32'hE);
        read_chk("cap_edge6", 0, 3, 32'h0);
        tick();
        read_chk("cap_edge7", 0, 3, 32'h1);
        chk("irq_masked", {31'd0, irq_a}, 32'd0);

        // Glitch rejection (3 cycles) and acceptance (4 cycles) on bit1
        wr(2'd3, 32'hF);
        in_a = 4'hC; ticks(3); in_a = 4'hE; ticks(8);
        read_chk("glitch3_data", 0, 0, 32'hE);
        read_chk("glitch3_cap", 0, 3, 32'h0);
        in_a = 4'hC; ticks(4); in_a = 4'hE; ticks(8);
        read_chk("pulse4_cap", 0, 3, 32'h2);
        read_chk("pulse4_data", 0, 0, 32'hE);

        // Mask enables irq the edge after the write; clear drops it
        wr(2'd3, 32'hF);
        in_a = 4'hF; ticks(8); in_a = 4'hE; ticks(8);
        read_chk("cap_bit0", 0, 3, 32'h1);
        wr(2'd2, 32'h1);
        chk("irq_on", {31'd0, irq_a}, 32'd1);
        read_chk("mask_rd", 0, 2, 32'h1);
        wr(2'd3, 32'h1);
        read_chk("cap_cleared", 0, 3, 32'h0);
        chk("irq_off", {31'd0, irq_a}, 32'd0);

        // Clear on the same edge as a new capture: set wins
        in_a = 4'hF; ticks(8); in_a = 4'hE; ticks(8);
        read_chk("cap_pre_race", 0, 3, 32'h1);
        in_a = 4'hF; ticks(8); in_a = 4'hE; ticks(6);
        wr(2'd3, 32'h1);
        read_chk("race_set_wins", 0, 3, 32'h1);
        chk("race_irq", {31'd0, irq_a}, 32'd1);
        wr(2'd3, 32'h1);
        read_chk("race_then_clear", 0, 3, 32'h0);

        // Bypass/any-edge instance: deb follows 3 edges after each change
        in_b = 4'h7; ticks(10);
        read_chk("b_data_low", 1, 0, 32'h7);
        read_chk("b_cap_first", 1, 3, 32'h8);
        wr(2'd3, 32'hF);
        in_b = 4'hF; ticks(2);
        read_chk("b_rise_edge2", 1, 0, 32'h7);
        tick();
        read_chk("b_rise_edge3", 1, 0, 32'hF);
        ticks(7);
        read_chk("b_cap_rise", 1, 3, 32'h8);
        in_b = 4'h7; ticks(2);
        read_chk("b_fall_edge2", 1, 0, 32'hF);
        tick();
        read_chk("b_fall_edge3", 1, 0, 32'h7);
        ticks(7);
        read_chk("b_cap_sticky", 1, 3, 32'h8);

        // Reset during a debounce count
        wr(2'd3, 32'hF);
        in_a = 4'hF; ticks(8);
        in_a = 4'hE; ticks(4);
        reset = 1'b1; tick(); reset = 1'b0;
        read_chk("midrst_data", 0, 0, 32'hF);
        read_chk("midrst_cap", 0, 3, 32'h0);
        ticks(4);
        read_chk("midrst_recount", 0, 0, 32'hF);
        ticks(8);
        in_a = 4'hF; ticks(8);
        in_a = 4'hE; ticks(3);
        in_a = 4'hF; reset = 1'b1; tick(); reset = 1'b0;
        ticks(10);
        read_chk("rst_abort_data", 0, 0, 32'hF);
        read_chk("rst_abort_cap", 0, 3, 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) in_a = 4'($urandom);
            if ($urandom_range(3) == 0) in_b = 4'($urandom);
            reset = ($urandom_range(99) == 0);
            address   = 2'($urandom);
            writedata = $urandom;
            chipselect = ($urandom_range(3) != 0);
            write_n    = ($urandom_range(4) != 0);
            tick();
            chipselect = 1'b0;
            write_n    = 1'b1;
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
